trace_buffer: RTL and testbench
===============================

TRACE_BUFFER -- requirements
Module: trace_buffer

Interface
REQ-001 SHALL have parameter DEPTH, default 16; entry count, power of 2, >= 2.
REQ-002 SHALL have parameter DATA_W, default 32; pc and insn width.
REQ-003 SHALL have parameter CYC_W, default 10; cycle-stamp width.
REQ-004 SHALL have parameter POST, default 4; entries captured after trigger, 0..DEPTH-1.
REQ-005 SHALL have port clk, input, 1; sole clock, rising edge.
REQ-006 SHALL have port reset, input, 1; asynchronous, active-low.
REQ-007 SHALL have port arm, input, 1; start-capture pulse.
REQ-008 SHALL have port valid, input, 1; instruction-retire strobe.
REQ-009 SHALL have port pc, input, DATA_W; retired pc.
REQ-010 SHALL have port insn, input, DATA_W; retired instruction.
REQ-011 SHALL have port trig_en, input, 1; pc-match trigger enable.
REQ-012 SHALL have port trig_pc, input, DATA_W; trigger pc.
REQ-013 SHALL have port rd_ready, input, 1; consumer ready.
REQ-014 SHALL have port rd_valid, output, 1; readout entry valid.
REQ-015 SHALL have port rd_pc / rd_insn, output, DATA_W each; oldest entry fields.
REQ-016 SHALL have port rd_cycle, output, CYC_W; oldest entry stamp.
REQ-017 SHALL have port state, output, 2; IDLE=0, CAPTURE=1, POST=2, READOUT=3.
REQ-018 SHALL have port count, output, clog2(DEPTH)+1; stored entries.
REQ-019 SHALL have port overflow, output, 1; sticky, set when an entry was overwritten.

Function
REQ-020 SHALL run a free CYC_W-bit cycle counter, +1 every clk, wrapping all-ones -> 0.
REQ-021 IDLE: arm=1 -> CAPTURE next cycle; wr pointer, count, overflow cleared; valid in the arm cycle not captured.
REQ-022 CAPTURE/POST: valid=1 writes {pc, insn, cycle counter} at wr_ptr; wr_ptr +1 mod DEPTH.
REQ-023 count SHALL saturate at DEPTH; a write at count==DEPTH overwrites the oldest entry and sets overflow.
REQ-024 CAPTURE: valid && trig_en && pc==trig_pc SHALL write that entry, load post counter with POST, and go to POST (POST=0: straight to READOUT).
REQ-025 POST: each write decrements the post counter; the write taking it to 0 moves to READOUT next cycle.
REQ-026 arm in CAPTURE or POST SHALL be ignored; valid in IDLE or READOUT SHALL be ignored.
REQ-027 READOUT: rd_valid = (count != 0); rd_* present the entry at (wr_ptr - count) mod DEPTH, oldest first, combinationally from storage.
REQ-028 rd_valid && rd_ready SHALL decrement count at that edge; next entry presented the following cycle.
REQ-029 rd_* SHALL hold stable while rd_valid && !rd_ready.
REQ-030 READOUT with count==0 SHALL go to IDLE next cycle.
REQ-031 arm in READOUT SHALL abort readout and behave as REQ-021; arm has priority over a simultaneous final handshake.
REQ-032 Cycle stamps SHALL be the counter value in the write cycle, no adjustment for wrap.

Reset
REQ-033 reset low SHALL immediately force state=IDLE, count=0, overflow=0, rd_valid=0, cycle counter=0, pointers=0, all storage=0 (rd_pc/rd_insn/rd_cycle=0).
REQ-034 reset mid-capture or mid-readout SHALL discard all entries; no partial readout after release.

Verification
REQ-035 Arm, 3 valids, reset low mid-cycle -> state 0, count 0, rd_valid 0 before the next edge.
REQ-036 DEPTH=16, POST=4, trig_pc=0x10; valids pc 0x0,0x4,...; trigger at 5th -> state 2; 4 more -> state 3, count 9; drain yields pc 0x0..0x20 in order, then IDLE.
REQ-037 POST=0, 21 valids, trigger on 21st -> READOUT, count 16, overflow 1, first rd_pc = pc of 6th valid.
REQ-038 READOUT, rd_ready low 3 cycles -> rd_pc/rd_insn/rd_cycle unchanged, count unchanged; rd_ready high -> advance one per cycle.
REQ-039 CYC_W=10, writes at counter 1023 and next cycle -> rd_cycle 1023 then 0.
REQ-040 arm during READOUT with count 5 -> state 1, count 0, overflow 0 next cycle.

Source files
------------

// File: rtl/trace_buffer.sv
`default_nettype none
// trace_buffer: armed, pc-triggered retire-trace ring buffer with oldest-first readout.
// Revision: 1.0

module trace_buffer #(
    parameter int DEPTH  = 16,
    parameter int DATA_W = 32,
    parameter int CYC_W  = 10,
    parameter int POST   = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       arm,
    input  logic                       valid,
    input  logic [DATA_W-1:0]          pc,
    input  logic [DATA_W-1:0]          insn,
    input  logic                       trig_en,
    input  logic [DATA_W-1:0]          trig_pc,
    input  logic                       rd_ready,
    output logic                       rd_valid,
    output logic [DATA_W-1:0]          rd_pc,
    output logic [DATA_W-1:0]          rd_insn,
    output logic [CYC_W-1:0]           rd_cycle,
    output logic [1:0]                 state,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       overflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_CAPTURE = 2'd1;
    localparam logic [1:0] S_POST    = 2'd2;
    localparam logic [1:0] S_READOUT = 2'd3;

    localparam logic [CW-1:0] FULL      = CW'(DEPTH);
    localparam logic [AW-1:0] POST_INIT = AW'(POST);

    logic [1:0]        state_q,    state_d;
    logic [AW-1:0]     wr_ptr_q,   wr_ptr_d;
    logic [CW-1:0]     count_q,    count_d;
    logic              ovf_q,      ovf_d;
    logic [AW-1:0]     post_q,     post_d;
    logic [CYC_W-1:0]  cyc_q;

    logic [DATA_W-1:0] pc_mem_q   [DEPTH];
    logic [DATA_W-1:0] insn_mem_q [DEPTH];
    logic [CYC_W-1:0]  cyc_mem_q  [DEPTH];

    logic              w_we;
    logic              w_hit;
    logic [AW-1:0]     w_rd_idx;

    assign w_we  = valid && ((state_q == S_CAPTURE) || (state_q == S_POST));
    assign w_hit = w_we && (state_q == S_CAPTURE) && trig_en && (pc == trig_pc);

    // With count==DEPTH the low bits are zero, so the oldest entry is wr_ptr itself.
    assign w_rd_idx = wr_ptr_q - count_q[AW-1:0];

    always_comb begin
        state_d  = state_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        ovf_d    = ovf_q;
        post_d   = post_q;

        if (w_we) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
            if (count_q == FULL) begin
                ovf_d = 1'b1;
            end else begin
                count_d = count_q + 1'b1;
            end
        end

        case (state_q)
            S_IDLE: begin
                if (arm) begin
                    state_d  = S_CAPTURE;
                    wr_ptr_d = '0;
                    count_d  = '0;
                    ovf_d    = 1'b0;
                end
            end
            S_CAPTURE: begin
                if (w_hit) begin
                    if (POST == 0) begin
                        state_d = S_READOUT;
                    end else begin
                        state_d = S_POST;
                        post_d  = POST_INIT;
                    end
                end
            end
            S_POST: begin
                if (w_we) begin
                    post_d = post_q - 1'b1;
                    if (post_q == AW'(1)) begin
                        state_d = S_READOUT;
                    end
                end
            end
            default: begin
                // Re-arm wins over a concurrent final handshake.
                if (arm) begin
                    state_d  = S_CAPTURE;
                    wr_ptr_d = '0;
                    count_d  = '0;
                    ovf_d    = 1'b0;
                end else if (count_q == '0) begin
                    state_d = S_IDLE;
                end else if (rd_ready) begin
                    count_d = count_q - 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            wr_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
            post_q   <= '0;
            cyc_q    <= '0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
            post_q   <= post_d;
            cyc_q    <= cyc_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                pc_mem_q[i]   <= '0;
                insn_mem_q[i] <= '0;
                cyc_mem_q[i]  <= '0;
            end
        end else if (w_we) begin
            pc_mem_q[wr_ptr_q]   <= pc;
            insn_mem_q[wr_ptr_q] <= insn;
            cyc_mem_q[wr_ptr_q]  <= cyc_q;
        end
    end

    assign rd_valid = (state_q == S_READOUT) && (count_q != '0);
    assign rd_pc    = pc_mem_q[w_rd_idx];
    assign rd_insn  = insn_mem_q[w_rd_idx];
    assign rd_cycle = cyc_mem_q[w_rd_idx];
    assign state    = state_q;
    assign count    = count_q;
    assign overflow = ovf_q;

endmodule

`default_nettype wire

// File: tb/tb_trace_buffer.sv
`default_nettype none
// tb_trace_buffer: directed bench with a scoreboard checking oldest-first readout.

module tb_trace_buffer;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] insn;
        logic [9:0]  cyc;
    } ent_t;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        arm = 1'b0;
    logic        valid = 1'b0;
    logic [31:0] pc = '0;
    logic [31:0] insn = '0;
    logic        trig_en_a = 1'b0;
    logic        trig_en_b = 1'b0;
    logic [31:0] trig_pc = '0;
    logic        rd_ready = 1'b0;

    logic        a_rd_valid, b_rd_valid;
    logic [31:0] a_rd_pc, a_rd_insn, b_rd_pc, b_rd_insn;
    logic [9:0]  a_rd_cycle, b_rd_cycle;
    logic [1:0]  a_state, b_state;
    logic [4:0]  a_count, b_count;
    logic        a_ovf, b_ovf;

    int          n_cmp = 0;
    int          n_err = 0;
    ent_t        sb_q[$];
    ent_t        mon_e;
    logic [9:0]  tb_cyc;
    int          guard;

    trace_buffer #(.DEPTH(16), .DATA_W(32), .CYC_W(10), .POST(4)) u_a (
        .clk(clk), .reset(reset), .arm(arm), .valid(valid), .pc(pc), .insn(insn),
        .trig_en(trig_en_a), .trig_pc(trig_pc), .rd_ready(rd_ready),
        .rd_valid(a_rd_valid), .rd_pc(a_rd_pc), .rd_insn(a_rd_insn), .rd_cycle(a_rd_cycle),
        .state(a_state), .count(a_count), .overflow(a_ovf)
    );

    trace_buffer #(.DEPTH(16), .DATA_W(32), .CYC_W(10), .POST(0)) u_b (
        .clk(clk), .reset(reset), .arm(arm), .valid(valid), .pc(pc), .insn(insn),
        .trig_en(trig_en_b), .trig_pc(trig_pc), .rd_ready(rd_ready),
        .rd_valid(b_rd_valid), .rd_pc(b_rd_pc), .rd_insn(b_rd_insn), .rd_cycle(b_rd_cycle),
        .state(b_state), .count(b_count), .overflow(b_ovf)
    );

    always #5 clk = ~clk;

    // Reference free-running stamp counter.
    always @(posedge clk or negedge reset) begin
        if (!reset) tb_cyc <= '0;
        else        tb_cyc <= tb_cyc + 10'd1;
    end

    // Monitor: every accepted entry of DUT A is checked against the scoreboard.
    always @(negedge clk) begin
        if (reset && a_rd_valid && rd_ready) begin
            n_cmp++;
            if (sb_q.size() == 0) begin
                n_err++;
                $display("FAIL sb_unexpected: got pc=%h insn=%h cyc=%0d, required no entry",
                         a_rd_pc, a_rd_insn, a_rd_cycle);
            end else begin
                mon_e = sb_q.pop_front();
                if ({a_rd_pc, a_rd_insn, a_rd_cycle} !== {mon_e.pc, mon_e.insn, mon_e.cyc}) begin
                    n_err++;
                    $display("FAIL sb_entry: got pc=%h insn=%h cyc=%0d, required pc=%h insn=%h cyc=%0d",
                             a_rd_pc, a_rd_insn, a_rd_cycle, mon_e.pc, mon_e.insn, mon_e.cyc);
                end
            end
        end
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, required %h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic a, input logic v, input logic [31:0] p,
                         input logic [31:0] ins, input bit push);
        arm = a; valid = v; pc = p; insn = ins;
        if (push) sb_q.push_back('{pc: p, insn: ins, cyc: tb_cyc});
        @(posedge clk); #1;
        arm = 1'b0; valid = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
    endtask

    initial begin
        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_state", a_state, 0);
        chk("rst_count", a_count, 0);
        chk("rst_rd_valid", a_rd_valid, 0);
        chk("rst_ovf", a_ovf, 0);
        chk("rst_rd_pc", a_rd_pc, 0);
        reset = 1'b1;

        // Reset asserted mid-capture takes effect before the next edge
        drive(1, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) drive(0, 1, 32'h40 + i, 32'h1 + i, 0);
        chk("mid_pre_count", a_count, 3);
        #2 reset = 1'b0;
        #1;
        chk("mid_rst_state", a_state, 0);
        chk("mid_rst_count", a_count, 0);
        chk("mid_rst_rd_valid", a_rd_valid, 0);
        @(posedge clk); #1 reset = 1'b1;
        @(posedge clk); #1;
        chk("mid_rst_after_state", a_state, 0);

        // POST=4 capture, trigger on 5th valid, readout with stall
        trig_en_a = 1'b1;
        trig_pc   = 32'h10;
        drive(1, 1, 32'hDEAD0000, 32'hDEAD, 0);
        for (int i = 0; i < 9; i++) begin
            drive((i == 1), 1, 32'(4 * i), 32'hA0000000 + 32'(i), 1);
            if (i == 3) chk("cap_state", a_state, 1);
            if (i == 4) chk("trig_state", a_state, 2);
        end
        chk("post_done_state", a_state, 3);
        chk("post_done_count", a_count, 9);
        chk("post_done_ovf", a_ovf, 0);
        chk("post_done_rd_valid", a_rd_valid, 1);
        for (int k = 0; k < 3; k++) begin
            chk("hold_pc", a_rd_pc, sb_q[0].pc);
            chk("hold_insn", a_rd_insn, sb_q[0].insn);
            chk("hold_cycle", a_rd_cycle, sb_q[0].cyc);
            chk("hold_count", a_count, 9);
            @(posedge clk); #1;
        end
        rd_ready = 1'b1;
        @(posedge clk); #1;
        chk("adv_count", a_count, 8);
        guard = 0;
        while (a_state != 2'd0 && guard < 30) begin
            @(posedge clk); #1;
            guard++;
        end
        rd_ready = 1'b0;
        chk("drain_idle_state", a_state, 0);
        chk("drain_sb_left", sb_q.size(), 0);
        trig_en_a = 1'b0;

        // POST=0 with wrap: 21 valids, trigger on the 21st
        do_reset();
        trig_en_b = 1'b1;
        trig_pc   = 32'h150;
        drive(1, 0, 0, 0, 0);
        for (int i = 0; i < 21; i++) drive(0, 1, 32'h100 + 32'(4 * i), 32'hB0000000 + 32'(i), 0);
        chk("ovf_b_state", b_state, 3);
        chk("ovf_b_count", b_count, 16);
        chk("ovf_b_ovf", b_ovf, 1);
        chk("ovf_b_rd_pc", b_rd_pc, 32'h114);
        chk("ovf_b_rd_insn", b_rd_insn, 32'hB0000005);
        chk("ovf_a_count", a_count, 16);
        chk("ovf_a_ovf", a_ovf, 1);

        // Drain to 5 entries then re-arm during readout
        rd_ready = 1'b1;
        repeat (11) @(posedge clk);
        #1 rd_ready = 1'b0;
        chk("abort_pre_count", b_count, 5);
        chk("abort_pre_rd_pc", b_rd_pc, 32'h100 + 32'(4 * 16));
        drive(1, 0, 0, 0, 0);
        chk("abort_state", b_state, 1);
        chk("abort_count", b_count, 0);
        chk("abort_ovf", b_ovf, 0);
        chk("abort_rd_valid", b_rd_valid, 0);
        chk("arm_ign_a_state", a_state, 1);
        chk("arm_ign_a_count", a_count, 16);

        // Cycle-stamp wrap: writes at counter 1023 and 0
        do_reset();
        trig_en_b = 1'b1;
        trig_pc   = 32'h2222;
        drive(1, 0, 0, 0, 0);
        guard = 0;
        while (tb_cyc != 10'd1023 && guard < 1100) begin
            @(posedge clk); #1;
            guard++;
        end
        chk("wrap_reached", tb_cyc, 10'd1023);
        drive(0, 1, 32'h1111, 32'hC1, 0);
        drive(0, 1, 32'h2222, 32'hC2, 0);
        chk("wrap_state", b_state, 3);
        chk("wrap_count", b_count, 2);
        chk("wrap_rd_pc0", b_rd_pc, 32'h1111);
        chk("wrap_rd_cycle0", b_rd_cycle, 10'd1023);
        rd_ready = 1'b1;
        @(posedge clk); #1 rd_ready = 1'b0;
        chk("wrap_rd_pc1", b_rd_pc, 32'h2222);
        chk("wrap_rd_cycle1", b_rd_cycle, 10'd0);
        chk("wrap_count1", b_count, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
